guess_round_ctrl: RTL and testbench
===================================

// Module: guess_round_ctrl
// PURPOSE
//  Round sequencer for the 4-button guess game. Sits between the board buttons
//  and guess_FSM (ports b[3:0], y[3:0], win, lose).
//  - Issues a sync restart and a step enable to the FSM.
//  - Gates the buttons through to the FSM only while a round is live.
//  - Scores each round, holds the result, and ends the game after MAX_ROUNDS.
// PARAMETERS
//  TICK_DIV     4   clk cycles per FSM step; fsm_en pulses once per TICK_DIV (>=2)
//  RESULT_HOLD  8   cycles the round result is held before the next round (>=1)
//  MAX_ROUNDS   5   rounds per game (1..15)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  reset        in   1  asynchronous, active-low; 0 forces all state to reset values
//  start        in   1  single-cycle start request (already debounced and pulsed)
//  btn          in   4  synchronized, debounced button levels
//  win          in   1  from guess_FSM, sampled every cycle
//  lose         in   1  from guess_FSM, sampled every cycle
//  fsm_b        out  4  buttons to guess_FSM: btn in PLAY, else 4'b0000 (combinational)
//  fsm_en       out  1  one-cycle step strobe to guess_FSM, PLAY only (registered)
//  fsm_clr      out  1  one-cycle synchronous restart to guess_FSM, CLEAR only (registered)
//  res_win      out  1  high throughout RESULT when the round was won
//  res_lose     out  1  high throughout RESULT when the round was lost
//  score        out  4  rounds won this game
//  misses       out  4  rounds lost this game
//  round        out  4  rounds completed this game
//  game_over    out  1  high in DONE
//  busy         out  1  high in CLEAR, PLAY and RESULT
// BEHAVIOUR
//  - Reset (reset=0, async) sets:
//    - state to IDLE;
//    - score, misses, round and the tick and hold counters to 0;
//    - every output to 0.
//  - States:
//    - IDLE: start -> CLEAR. On that edge score, misses and round are zeroed.
//    - CLEAR: fsm_clr=1 for exactly 1 cycle; the tick counter is zeroed.
//      Always goes to PLAY on the next cycle.
//    - PLAY:
//      - The tick counter counts 0..TICK_DIV-1 and wraps.
//      - fsm_en=1 in the cycle after the counter reads TICK_DIV-1.
//      - The first fsm_en comes TICK_DIV cycles after entering PLAY.
//      - On win or lose -> RESULT. If both are high, lose takes priority.
//      - On entry to RESULT: a win increments score, a lose increments misses;
//        round increments in both cases.
//      - score and misses saturate at 15.
//    - RESULT:
//      - fsm_b=0 and fsm_en=0.
//      - res_win or res_lose is held for at least RESULT_HOLD cycles.
//      - Exit requires both: the hold count has elapsed AND btn==4'b0000,
//        so a held button cannot retrigger. Stay until both are true.
//      - Exit goes to DONE if round==MAX_ROUNDS, otherwise to CLEAR.
//    - DONE: game_over=1. start -> CLEAR with score, misses and round zeroed
//      on that edge.
//  - start is ignored in CLEAR, PLAY and RESULT.
//  - win and lose are ignored outside PLAY.
//  - Within a round, fsm_clr strictly precedes the first fsm_en.
//  - fsm_en and fsm_clr are never high in the same cycle.
//  - Reset asserted mid-round returns to IDLE immediately. fsm_b drops to 0
//    in the same cycle (combinational path from state).
//  - Counter widths: tick counter clog2(TICK_DIV); hold counter clog2(RESULT_HOLD+1).
// TESTING  (TICK_DIV=2, RESULT_HOLD=3, MAX_ROUNDS=2)
//  1. reset=0 then 1; no start for 10 cycles -> all outputs 0, busy=0, fsm_b=0
//     even with btn=4'b1111.
//  2. Pulse start -> fsm_clr=1 for 1 cycle, then fsm_en pulses every 2nd cycle;
//     btn=4'b0001 appears on fsm_b.
//  3. Drive win=1 in PLAY -> res_win=1 for 3 cycles, score=1, round=1,
//     fsm_b=0 during RESULT. Then fsm_clr pulses and the next round starts.
//  4. Hold btn=4'b0100 through the end of RESULT -> remain in RESULT with res
//     held until btn=0, then CLEAR.
//  5. win=1 and lose=1 together in round 2 -> misses=1, score unchanged,
//     round=2, then game_over=1. start in DONE -> counters cleared, fsm_clr pulses.
//  6. reset=0 mid-PLAY and start pulsed during PLAY -> start has no effect.
//     On reset=0: IDLE, fsm_b=0 in the same cycle, all counters 0.

Source files
------------

// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round sequencer for the 4-button guess game.
// Restarts and steps guess_FSM, gates the buttons through to it while a
// round is live, scores each round, holds the result, and ends the game
// after MAX_ROUNDS rounds.
module guess_round_ctrl #(
    parameter int TICK_DIV    = 4,
    parameter int RESULT_HOLD = 8,
    parameter int MAX_ROUNDS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic       win,
    input  logic       lose,
    output logic [3:0] fsm_b,
    output logic       fsm_en,
    output logic       fsm_clr,
    output logic       res_win,
    output logic       res_lose,
    output logic [3:0] score,
    output logic [3:0] misses,
    output logic [3:0] round,
    output logic       game_over,
    output logic       busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(RESULT_HOLD + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(RESULT_HOLD - 1);
    localparam logic [3:0]    ROUNDS_LAST = 4'(MAX_ROUNDS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [TW-1:0] r_tick;
    logic [HW-1:0] r_hold;
    logic [3:0]    r_score;
    logic [3:0]    r_misses;
    logic [3:0]    r_round;
    logic          r_fsm_en;
    logic          r_fsm_clr;
    logic          r_res_win;
    logic          r_res_lose;
    logic          w_hit;
    logic          w_hold_done;
    logic          w_new_game;
    logic          w_leave_res;

    // a round ends only on a win/lose seen while playing
    assign w_hit       = (r_state == S_PLAY) && (win || lose);
    // hold counter reads RESULT_HOLD-1 in the last mandatory result cycle
    assign w_hold_done = (r_hold >= HOLD_LAST);
    assign w_new_game  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_leave_res = (r_state == S_RESULT) && (w_next != S_RESULT);

    // next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_CLEAR;
            S_CLEAR:        w_next = S_PLAY;
            S_PLAY:         if (win || lose) w_next = S_RESULT;
            S_RESULT: begin
                // a still-held button keeps us here so it cannot retrigger
                if (w_hold_done && (btn == 4'b0000))
                    w_next = (r_round == ROUNDS_LAST) ? S_DONE : S_CLEAR;
            end
            default:        w_next = S_IDLE;
        endcase
    end

    // state register and the registered FSM strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_fsm_clr <= 1'b0;
            r_fsm_en  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_fsm_clr <= (w_next == S_CLEAR);
            // suppressed when the round ends on this edge so it stays PLAY-only
            r_fsm_en  <= (r_state == S_PLAY) && !w_hit && (r_tick == TICK_LAST);
        end
    end

    // step divider: runs only in PLAY, held at zero elsewhere (incl. CLEAR)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_tick <= '0;
        else if (r_state == S_PLAY)
            r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
        else
            r_tick <= '0;
    end

    // result hold timer: counts result cycles and saturates once elapsed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_hold <= '0;
        else if (r_state != S_RESULT)
            r_hold <= '0;
        else if (!w_hold_done)
            r_hold <= r_hold + 1'b1;
    end

    // game scoring; lose wins a tie with win
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_score  <= 4'd0;
            r_misses <= 4'd0;
            r_round  <= 4'd0;
        end else if (w_new_game) begin
            r_score  <= 4'd0;
            r_misses <= 4'd0;
            r_round  <= 4'd0;
        end else if (w_hit) begin
            r_round <= r_round + 4'd1;
            if (lose) begin
                if (r_misses != 4'd15) r_misses <= r_misses + 4'd1;
            end else begin
                if (r_score != 4'd15) r_score <= r_score + 4'd1;
            end
        end
    end

    // round result flags, held for the whole RESULT state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_win  <= 1'b0;
            r_res_lose <= 1'b0;
        end else if (w_hit) begin
            r_res_win  <= !lose;
            r_res_lose <= lose;
        end else if (w_leave_res) begin
            r_res_win  <= 1'b0;
            r_res_lose <= 1'b0;
        end
    end

    assign fsm_b     = (r_state == S_PLAY) ? btn : 4'b0000;
    assign fsm_en    = r_fsm_en;
    assign fsm_clr   = r_fsm_clr;
    assign res_win   = r_res_win;
    assign res_lose  = r_res_lose;
    assign score     = r_score;
    assign misses    = r_misses;
    assign round     = r_round;
    assign game_over = (r_state == S_DONE);
    assign busy      = (r_state == S_CLEAR) || (r_state == S_PLAY) || (r_state == S_RESULT);

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl: random games driven from a round-level model.
// The driver predicts strobe/result events into a queue; a negedge monitor
// pops them as the DUT shows them and also checks the level outputs.
module tb_guess_round_ctrl;
    localparam int TD = 2;
    localparam int RH = 3;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       win = 1'b0;
    logic       lose = 1'b0;
    logic [3:0] btn = 4'hF;
    logic [3:0] fsm_b, score, misses, round;
    logic       fsm_en, fsm_clr, res_win, res_lose, game_over, busy;

    always #5 clk = ~clk;

    guess_round_ctrl #(.TICK_DIV(TD), .RESULT_HOLD(RH), .MAX_ROUNDS(MR)) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .win(win), .lose(lose),
        .fsm_b(fsm_b), .fsm_en(fsm_en), .fsm_clr(fsm_clr), .res_win(res_win),
        .res_lose(res_lose), .score(score), .misses(misses), .round(round),
        .game_over(game_over), .busy(busy)
    );

    typedef enum logic [1:0] {EV_CLR, EV_EN, EV_RES, EV_OVER} ev_kind_t;
    typedef struct { ev_kind_t kind; int cyc; } ev_t;
    ev_t q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // round-level model of what the outputs should be in the current cycle
    bit m_play = 0, m_busy = 0, m_over = 0, m_rw = 0, m_rl = 0;
    int m_score = 0, m_miss = 0, m_round = 0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic see(input ev_kind_t k);
        ev_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d at cyc %0d want none", k, cyc);
        end else begin
            e = q.pop_front();
            chk("ev_kind", 32'(k), 32'(e.kind));
            chk("ev_cyc", cyc, e.cyc);
        end
    endtask

    // monitor: level outputs every cycle, strobes/results against the queue
    bit p_res = 0, p_over = 0;
    always @(negedge clk) begin
        ev_t e;
        chk("fsm_b", 32'(fsm_b), 32'(m_play ? btn : 4'h0));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("game_over", 32'(game_over), 32'(m_over));
        chk("res_win", 32'(res_win), 32'(m_rw));
        chk("res_lose", 32'(res_lose), 32'(m_rl));
        chk("score", 32'(score), m_score);
        chk("misses", 32'(misses), m_miss);
        chk("round", 32'(round), m_round);
        chk("en_clr_excl", 32'(fsm_en & fsm_clr), 32'd0);
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got none want kind %0d at cyc %0d", e.kind, e.cyc);
        end
        if (fsm_clr) see(EV_CLR);
        if (fsm_en) see(EV_EN);
        if ((res_win || res_lose) && !p_res) see(EV_RES);
        if (game_over && !p_over) see(EV_OVER);
        p_res  = res_win || res_lose;
        p_over = game_over;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // idle cycles in IDLE/DONE: buttons and win/lose are don't-cares
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            btn = 4'($urandom);
            win = 1'($urandom);
            lose = 1'($urandom);
        end
    endtask

    // called from IDLE/DONE; returns in the CLEAR cycle
    task automatic start_game();
        start = 1'b1;
        push(EV_CLR, cyc + 1);
        tick();
        start = 1'($urandom);
        win = 1'($urandom);
        lose = 1'($urandom);
        m_score = 0; m_miss = 0; m_round = 0;
        m_busy = 1; m_over = 0;
    endtask

    // outcome 0=win 1=lose 2=both; L play cycles; B result cycles with btn held
    // called in the CLEAR cycle; returns in the cycle after RESULT (or after reset)
    task automatic play_round(input int outcome, input int L, input int B, input bit abort);
        int n, K;
        n = cyc;
        for (int c = n + 1 + TD; c <= n + L; c += TD)
            if (!abort || c < n + L) push(EV_EN, c);
        if (!abort) push(EV_RES, n + L + 1);
        for (int i = 1; i <= L; i++) begin
            tick();
            m_play = 1;
            btn = 4'($urandom);
            start = 1'($urandom);
            win = 1'b0;
            lose = 1'b0;
            if (i == L) begin
                if (abort) begin
                    btn = 4'hF;
                    reset = 1'b0;
                    q.delete();
                    m_play = 0; m_busy = 0; m_over = 0; m_rw = 0; m_rl = 0;
                    m_score = 0; m_miss = 0; m_round = 0;
                    #1;
                    chk("rst_fsm_b", 32'(fsm_b), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_round", 32'(round), 32'd0);
                    chk("rst_score", 32'(score), 32'd0);
                    tick();
                    reset = 1'b1;
                    start = 1'b0;
                    return;
                end
                win = (outcome != 1);
                lose = (outcome != 0);
            end
        end
        tick();
        m_play = 0;
        m_round++;
        if (outcome == 0) m_score = (m_score < 15) ? m_score + 1 : 15;
        else              m_miss  = (m_miss  < 15) ? m_miss  + 1 : 15;
        m_rw = (outcome == 0);
        m_rl = (outcome != 0);
        K = (B > RH - 1) ? B : RH - 1;
        for (int k = 0; k <= K; k++) begin
            if (k > 0) tick();
            btn = (k < B) ? 4'($urandom_range(1, 15)) : 4'h0;
            win = 1'($urandom);
            lose = 1'($urandom);
            start = 1'($urandom);
        end
        tick();
        start = 1'b0;
        m_rw = 0;
        m_rl = 0;
        if (m_round == MR) begin
            m_busy = 0;
            m_over = 1;
            push(EV_OVER, cyc);
        end else begin
            push(EV_CLR, cyc);
        end
    endtask

    initial begin
        // reset, then a quiet IDLE with all buttons pressed
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            btn = 4'hF;
        end
        // directed game: clean win, then a tie (lose priority) with a held button
        start_game();
        play_round(0, 5, 0, 0);
        play_round(2, 3, RH + 2, 0);
        idle(3);
        // restart from DONE, then abort mid-PLAY with reset
        start_game();
        play_round(1, 4, 1, 0);
        play_round(0, 5, 0, 1);
        idle(4);
        // random games, some aborted
        for (int g = 0; g < 25; g++) begin
            start_game();
            for (int r = 0; r < MR; r++) begin
                bit ab;
                ab = ($urandom_range(0, 9) == 0);
                play_round($urandom_range(0, 2), $urandom_range(1, 7),
                           $urandom_range(0, RH + 3), ab);
                if (ab) break;
            end
            idle($urandom_range(0, 3));
        end
        idle(4);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
